// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the EXE stage: multi-cycle MULT/MULTU and restoring
// DIV/DIVU producing registered HI/LO, with pipeline stall, hold and flush handshakes.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  EXE_MultDivOp,
    input  logic [31:0] EXE_rs,
    input  logic [31:0] EXE_rt,
    input  logic        EXE_Wr,
    input  logic        Flush,
    output logic        DIVMULTBusy,
    output logic        Result_Valid,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [4:0] MUL_LAST = 5'(MULT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        op_valid, op_is_mul, in_neg;
    logic [31:0] in_mag;
    logic        is_signed, a_neg, b_neg, q_neg;
    logic [31:0] b_mag;
    logic [63:0] a_ext, b_ext, prod;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_next, quo_next;

    always_comb begin
        op_valid  = (EXE_MultDivOp != 3'b000) && (EXE_MultDivOp <= OP_DIVU);
        op_is_mul = (EXE_MultDivOp == OP_MULT) || (EXE_MultDivOp == OP_MULTU);
        in_neg    = (EXE_MultDivOp == OP_DIV) && EXE_rs[31];
        in_mag    = in_neg ? -EXE_rs : EXE_rs;

        is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
        a_neg     = is_signed && a_q[31];
        b_neg     = is_signed && b_q[31];
        q_neg     = a_neg ^ b_neg;
        b_mag     = b_neg ? -b_q : b_q;

        // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then exact
        a_ext = {{32{a_neg}}, a_q};
        b_ext = {{32{b_neg}}, b_q};
        prod  = a_ext * b_ext;

        // One restoring step: shift next dividend bit into the partial remainder
        rem_sh   = {rem_q, quo_q[31]};
        fits     = rem_sh >= {1'b0, b_mag};
        rem_next = fits ? 32'(rem_sh - {1'b0, b_mag}) : rem_sh[31:0];
        quo_next = {quo_q[30:0], fits};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (Flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        op_d = EXE_MultDivOp;
                        a_d  = EXE_rs;
                        b_d  = EXE_rt;
                        if (op_is_mul) begin
                            state_d = MUL;
                            cnt_d   = MUL_LAST;
                        end else begin
                            state_d = DIV;
                            cnt_d   = 5'd31;
                            rem_d   = '0;
                            quo_d   = in_mag;
                        end
                    end
                end
                MUL: begin
                    if (cnt_q == 5'd0) begin
                        state_d = DONE;
                        hi_d    = prod[63:32];
                        lo_d    = prod[31:0];
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                DIV: begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    if (cnt_q == 5'd0) begin
                        state_d = DONE;
                        if (b_q == 32'd0) begin
                            hi_d = a_q;
                            lo_d = 32'hFFFF_FFFF;
                        end else begin
                            hi_d = a_neg ? -rem_next : rem_next;
                            lo_d = q_neg ? -quo_next : quo_next;
                        end
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                DONE: begin
                    if (EXE_Wr) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        DIVMULTBusy  = !Flush && (((state_q == IDLE) && op_valid) ||
                                  (state_q == MUL) || (state_q == DIV));
        Result_Valid = !Flush && (state_q == DONE);
        HI_out       = hi_q;
        LO_out       = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops checked
// against an arithmetic reference model, including stall, flush and reset behaviour.
module tb_mult_div_unit;

    localparam int unsigned MC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  EXE_MultDivOp;
    logic [31:0] EXE_rs, EXE_rt;
    logic        EXE_Wr, Flush;
    logic        DIVMULTBusy, Result_Valid;
    logic [31:0] HI_out, LO_out;

    int errors = 0;
    int checks = 0;
    logic [63:0] last_hl = '0;

    mult_div_unit #(.MULT_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .EXE_MultDivOp(EXE_MultDivOp), .EXE_rs(EXE_rs),
        .EXE_rt(EXE_rt), .EXE_Wr(EXE_Wr), .Flush(Flush), .DIVMULTBusy(DIVMULTBusy),
        .Result_Valid(Result_Valid), .HI_out(HI_out), .LO_out(LO_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: {HI, LO} from plain 64-bit integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt);
        longint a, b, r;
        logic [63:0] v;
        bit sgn;
        sgn = (op == 3'b001) || (op == 3'b011);
        a = sgn ? longint'($signed(rs)) : longint'({32'b0, rs});
        b = sgn ? longint'($signed(rt)) : longint'({32'b0, rt});
        if (op == 3'b001 || op == 3'b010) begin
            r = a * b;
            v = r;
        end else if (rt == 32'd0) begin
            v = {rs, 32'hFFFF_FFFF};
        end else begin
            r = a / b;
            v[31:0] = r[31:0];
            r = a % b;
            v[63:32] = r[31:0];
        end
        return v;
    endfunction

    // Issue one op in IDLE, count busy cycles until DONE, then hold DONE for `stall` cycles
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [63:0] exp, input int stall);
        int busy_n, n, lat;
        lat = (op == 3'b001 || op == 3'b010) ? MC : 32;
        @(negedge clk);
        EXE_MultDivOp = op; EXE_rs = rs; EXE_rt = rt; EXE_Wr = 1'b1;
        busy_n = 0; n = 0;
        while (n < 64) begin
            #1;
            if (Result_Valid) break;
            if (DIVMULTBusy) busy_n++;
            n++;
            @(negedge clk);
            EXE_MultDivOp = 3'($urandom_range(0, 7));
            EXE_rs = $urandom; EXE_rt = $urandom;
        end
        check({tag, " busy cycles"}, 64'(busy_n), 64'(lat + 1));
        check({tag, " result"}, {HI_out, LO_out}, exp);
        check({tag, " done busy"}, {63'd0, DIVMULTBusy}, 64'd0);
        last_hl = exp;
        EXE_Wr = (stall == 0);
        EXE_MultDivOp = 3'b000;
        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            EXE_Wr = (s == stall);
            EXE_MultDivOp = 3'($urandom_range(1, 4));
            #1;
            check({tag, " held {rv,busy}"}, {62'd0, Result_Valid, DIVMULTBusy}, 64'd2);
        end
        @(negedge clk);
        EXE_MultDivOp = 3'b000; EXE_Wr = 1'b1;
        #1;
        check({tag, " idle {rv,busy}"}, {62'd0, Result_Valid, DIVMULTBusy}, 64'd0);
        check({tag, " hold hi/lo"}, {HI_out, LO_out}, exp);
    endtask

    // Watch `n` cycles with no op; Result_Valid must never rise
    task automatic no_result(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            if (Result_Valid) seen++;
        end
        check({tag, " no result"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] rs, rt;
        rst = 1'b0; EXE_MultDivOp = '0; EXE_rs = '0; EXE_rt = '0; EXE_Wr = 1'b1; Flush = 1'b0;
        #12;
        check("reset hi/lo", {HI_out, LO_out}, 64'd0);
        check("reset {rv,busy}", {62'd0, Result_Valid, DIVMULTBusy}, 64'd0);
        @(negedge clk); rst = 1'b1;

        do_op("mult", 3'b001, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 0);
        do_op("multu", 3'b010, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 0);
        do_op("div -7/2", 3'b011, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        do_op("divu /0", 3'b100, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF, 0);
        do_op("div ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
        do_op("div /0", 3'b011, 32'h8000_0001, 32'd0, 64'h8000_0001_FFFF_FFFF, 0);
        do_op("mult stall", 3'b001, 32'h0000_1234, 32'hFFFF_0000,
              model(3'b001, 32'h0000_1234, 32'hFFFF_0000), 3);

        // Flush during DIV iteration
        @(negedge clk);
        EXE_MultDivOp = 3'b011; EXE_rs = 32'd1000; EXE_rt = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            EXE_MultDivOp = 3'b000;
        end
        Flush = 1'b1;
        #1;
        check("flush {rv,busy}", {62'd0, Result_Valid, DIVMULTBusy}, 64'd0);
        @(negedge clk);
        Flush = 1'b0;
        #1;
        check("after flush {rv,busy}", {62'd0, Result_Valid, DIVMULTBusy}, 64'd0);
        no_result("flush", 40);
        check("flush hi/lo kept", {HI_out, LO_out}, last_hl);

        // Flush coinciding with a new op in IDLE
        @(negedge clk);
        EXE_MultDivOp = 3'b001; EXE_rs = 32'd5; EXE_rt = 32'd6; Flush = 1'b1;
        #1;
        check("flush issue busy", {63'd0, DIVMULTBusy}, 64'd0);
        @(negedge clk);
        EXE_MultDivOp = 3'b000; Flush = 1'b0;
        no_result("flush issue", 6);
        check("flush issue hi/lo", {HI_out, LO_out}, last_hl);

        for (int k = 0; k < 20; k++) begin
            op = 3'($urandom_range(1, 4));
            rs = $urandom;
            rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rt = rt & 32'h0000_00FF;
            do_op("rand", op, rs, rt, model(op, rs, rt), $urandom_range(0, 2));
        end

        // Reset during DIV
        @(negedge clk);
        EXE_MultDivOp = 3'b100; EXE_rs = 32'hDEAD_BEEF; EXE_rt = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            EXE_MultDivOp = 3'b000;
        end
        rst = 1'b0;
        #1;
        check("mid reset hi/lo", {HI_out, LO_out}, 64'd0);
        check("mid reset {rv,busy}", {62'd0, Result_Valid, DIVMULTBusy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        no_result("reset", 40);
        check("post reset hi/lo", {HI_out, LO_out}, 64'd0);

        do_op("post reset mult", 3'b010, 32'd9, 32'd11, 64'd99, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
